// File: rtl/photon_hls_deadlock_report_unit.sv
// Deadlock report controller: picks an origin, logs the token walk, streams the chain out. Optional watchdog: DEADLOCK_REPORT_TIMEOUT_EN.
// Latency: outputs registered; the origin pulse appears one cycle after dl_in_vec_i is sampled.
// Backpressure: report beats hold steady while report_ready_i is low; one beat per cycle when it is high.
module photon_hls_deadlock_report_unit #(
    parameter int PROC_NUM     = 4,
    parameter int CHAIN_DEPTH  = 4,
    parameter int IDX_W        = 2,
    parameter int WALK_TIMEOUT = 255
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [PROC_NUM-1:0] dl_in_vec_i,
    input  logic [PROC_NUM-1:0] token_seen_vec_i,
    output logic [PROC_NUM-1:0] origin_vec_o,
    output logic                dl_detect_bcast_o,
    output logic [PROC_NUM-1:0] token_clear_vec_o,
    output logic                report_valid_o,
    output logic [IDX_W-1:0]    report_idx_o,
    output logic                report_last_o,
    output logic [1:0]          report_status_o,
    input  logic                report_ready_i,
    output logic                deadlock_flag_o,
    input  logic                clear_i
);

    localparam int CNT_W = $clog2(CHAIN_DEPTH) + 1;
    localparam logic [1:0] ST_CLOSED   = 2'b00;
    localparam logic [1:0] ST_OVERFLOW = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ORIGIN, S_WALK, S_REPORT, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      org_q, org_d;
    logic [IDX_W-1:0]      log_q [CHAIN_DEPTH];
    logic [IDX_W-1:0]      log_d [CHAIN_DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0]            status_q, status_d;
    logic                  flag_q, flag_d;

    logic [PROC_NUM-1:0]   origin_q, origin_d;
    logic                  bcast_q, bcast_d;
    logic [PROC_NUM-1:0]   tclr_q, tclr_d;
    logic                  valid_q, valid_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  last_q, last_d;

    logic [PROC_NUM-1:0]   org_mask;
    logic [PROC_NUM-1:0]   in_log;
    logic [PROC_NUM-1:0]   cand;
    logic [PROC_NUM-1:0]   dl_low_mask;
    logic [IDX_W-1:0]      dl_low;
    logic [IDX_W-1:0]      cand_low;
    logic                  wd_expire;

    always_comb begin
        org_mask = '0;
        in_log   = '0;
        dl_low   = '0;
        cand_low = '0;
        for (int p = 0; p < PROC_NUM; p++) begin
            if (IDX_W'(p) == org_q) begin
                org_mask[p] = 1'b1;
            end
            for (int k = 0; k < CHAIN_DEPTH; k++) begin
                if ((CNT_W'(k) < count_q) && (log_q[k] == IDX_W'(p))) begin
                    in_log[p] = 1'b1;
                end
            end
        end
        cand = token_seen_vec_i & ~in_log;
        // Descending scan so the lowest set index is the one left standing.
        for (int p = PROC_NUM - 1; p >= 0; p--) begin
            if (dl_in_vec_i[p]) begin
                dl_low = IDX_W'(p);
            end
            if (cand[p]) begin
                cand_low = IDX_W'(p);
            end
        end
    end

    assign dl_low_mask = dl_in_vec_i & (~dl_in_vec_i + PROC_NUM'(1));

`ifdef DEADLOCK_REPORT_TIMEOUT_EN
    localparam int WD_W = ($clog2(WALK_TIMEOUT + 1) > 8) ? $clog2(WALK_TIMEOUT + 1) : 8;
    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_expire = (state_q == S_WALK) && (wd_q == WD_W'(WALK_TIMEOUT - 1));

    // Restarts on WALK entry and on every append (an append is the only way count moves in WALK).
    always_comb begin
        wd_d = '0;
        if ((state_q == S_WALK) && (state_d == S_WALK) && (count_d == count_q)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        org_d    = org_q;
        log_d    = log_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        status_d = status_q;
        flag_d   = flag_q;
        origin_d = '0;
        tclr_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|dl_in_vec_i) begin
                    org_d    = dl_low;
                    log_d[0] = dl_low;
                    count_d  = CNT_W'(1);
                    rd_ptr_d = '0;
                    flag_d   = 1'b1;
                    origin_d = dl_low_mask;
                    state_d  = S_ORIGIN;
                end
            end
            S_ORIGIN: begin
                state_d = S_WALK;
            end
            S_WALK: begin
                if (|(token_seen_vec_i & org_mask)) begin
                    tclr_d   = org_mask;
                    status_d = ST_CLOSED;
                    rd_ptr_d = '0;
                    state_d  = S_REPORT;
                end else if (|cand) begin
                    if (count_q < CNT_W'(CHAIN_DEPTH)) begin
                        for (int k = 0; k < CHAIN_DEPTH; k++) begin
                            if (CNT_W'(k) == count_q) begin
                                log_d[k] = cand_low;
                            end
                        end
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        status_d = ST_OVERFLOW;
                        rd_ptr_d = '0;
                        state_d  = S_REPORT;
                    end
                end else if (wd_expire) begin
                    tclr_d   = org_mask;
                    status_d = ST_TIMEOUT;
                    rd_ptr_d = '0;
                    state_d  = S_REPORT;
                end
            end
            S_REPORT: begin
                if (valid_q && report_ready_i) begin
                    if (last_q) begin
                        state_d = S_HALT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d  = S_IDLE;
            org_d    = '0;
            count_d  = '0;
            rd_ptr_d = '0;
            status_d = ST_CLOSED;
            flag_d   = 1'b0;
            origin_d = '0;
            tclr_d   = '0;
            for (int k = 0; k < CHAIN_DEPTH; k++) begin
                log_d[k] = '0;
            end
        end
    end

    // Report outputs are decoded from next-state so they are registered yet aligned with the state.
    always_comb begin
        bcast_d = (state_d != S_IDLE);
        valid_d = (state_d == S_REPORT);
        last_d  = (state_d == S_REPORT) && (rd_ptr_d == (count_d - CNT_W'(1)));
        idx_d   = '0;
        if (state_d == S_REPORT) begin
            for (int k = 0; k < CHAIN_DEPTH; k++) begin
                if (CNT_W'(k) == rd_ptr_d) begin
                    idx_d = log_d[k];
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            org_q    <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            status_q <= ST_CLOSED;
            flag_q   <= 1'b0;
            origin_q <= '0;
            bcast_q  <= 1'b0;
            tclr_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            for (int k = 0; k < CHAIN_DEPTH; k++) begin
                log_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            org_q    <= org_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            status_q <= status_d;
            flag_q   <= flag_d;
            origin_q <= origin_d;
            bcast_q  <= bcast_d;
            tclr_q   <= tclr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            for (int k = 0; k < CHAIN_DEPTH; k++) begin
                log_q[k] <= log_d[k];
            end
        end
    end

    assign origin_vec_o      = origin_q;
    assign dl_detect_bcast_o = bcast_q;
    assign token_clear_vec_o = tclr_q;
    assign report_valid_o    = valid_q;
    assign report_idx_o      = idx_q;
    assign report_last_o     = last_q;
    assign report_status_o   = status_q;
    assign deadlock_flag_o   = flag_q;

endmodule

// File: tb/tb_photon_hls_deadlock_report_unit.sv
// Directed bench: vector table on a 4-deep instance, hand sequences for reset, overflow (2-deep) and timeout.
module tb_photon_hls_deadlock_report_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] dl_a = '0, tok_a = '0;
    logic       rdy_a = 1'b0, clr_a = 1'b0;
    logic [3:0] origin_a, tclr_a;
    logic       bcast_a, valid_a, last_a, flag_a;
    logic [1:0] idx_a, status_a;

    logic [3:0] dl_b = '0, tok_b = '0;
    logic       rdy_b = 1'b0, clr_b = 1'b0;
    logic [3:0] origin_b, tclr_b;
    logic       bcast_b, valid_b, last_b, flag_b;
    logic [1:0] idx_b, status_b;

    photon_hls_deadlock_report_unit #(
        .PROC_NUM(4), .CHAIN_DEPTH(4), .IDX_W(2), .WALK_TIMEOUT(10)
    ) dut_a (
        .clock_i(clk), .reset_i(rst),
        .dl_in_vec_i(dl_a), .token_seen_vec_i(tok_a),
        .origin_vec_o(origin_a), .dl_detect_bcast_o(bcast_a),
        .token_clear_vec_o(tclr_a), .report_valid_o(valid_a),
        .report_idx_o(idx_a), .report_last_o(last_a),
        .report_status_o(status_a), .report_ready_i(rdy_a),
        .deadlock_flag_o(flag_a), .clear_i(clr_a)
    );

    photon_hls_deadlock_report_unit #(
        .PROC_NUM(4), .CHAIN_DEPTH(2), .IDX_W(2), .WALK_TIMEOUT(10)
    ) dut_b (
        .clock_i(clk), .reset_i(rst),
        .dl_in_vec_i(dl_b), .token_seen_vec_i(tok_b),
        .origin_vec_o(origin_b), .dl_detect_bcast_o(bcast_b),
        .token_clear_vec_o(tclr_b), .report_valid_o(valid_b),
        .report_idx_o(idx_b), .report_last_o(last_b),
        .report_status_o(status_b), .report_ready_i(rdy_b),
        .deadlock_flag_o(flag_b), .clear_i(clr_b)
    );

    // Packed as {origin, bcast, token_clear, valid, idx, last, status, flag}.
    wire [15:0] out_a = {origin_a, bcast_a, tclr_a, valid_a, idx_a, last_a, status_a, flag_a};
    wire [15:0] out_b = {origin_b, bcast_b, tclr_b, valid_b, idx_b, last_b, status_b, flag_b};

    typedef struct {
        logic [3:0]  dl;
        logic [3:0]  tok;
        logic        rdy;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    int total = 0;
    int bad = 0;

    function automatic logic [15:0] ex(input logic [3:0] origin, input logic bcast,
                                       input logic [3:0] tclr, input logic valid,
                                       input logic [1:0] idx, input logic last,
                                       input logic [1:0] status, input logic flag);
        return {origin, bcast, tclr, valid, idx, last, status, flag};
    endfunction

    function automatic vec_t mk(input logic [3:0] dl, input logic [3:0] tok,
                                input logic rdy, input logic clr, input logic [15:0] e);
        vec_t v;
        v.dl = dl; v.tok = tok; v.rdy = rdy; v.clr = clr; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    vec_t vecs [23];

    initial begin
        // dl, tok, rdy, clr -> {origin,bcast,tclr,valid,idx,last,status,flag}
        vecs[0]  = mk(4'h0, 4'h0, 0, 0, ex(4'h0, 0, 4'h0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(4'h6, 4'h0, 0, 0, ex(4'h2, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[2]  = mk(4'h6, 4'h0, 0, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[3]  = mk(4'h0, 4'h4, 0, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[4]  = mk(4'h0, 4'h4, 0, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[5]  = mk(4'h0, 4'h8, 0, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[6]  = mk(4'h0, 4'h2, 0, 0, ex(4'h0, 1, 4'h2, 1, 1, 0, 0, 1));
        for (int i = 7; i <= 11; i++)
            vecs[i] = mk(4'h0, 4'h0, 0, 0, ex(4'h0, 1, 4'h0, 1, 1, 0, 0, 1));
        vecs[12] = mk(4'h0, 4'h0, 1, 0, ex(4'h0, 1, 4'h0, 1, 2, 0, 0, 1));
        vecs[13] = mk(4'h0, 4'h0, 1, 0, ex(4'h0, 1, 4'h0, 1, 3, 1, 0, 1));
        vecs[14] = mk(4'h0, 4'h0, 1, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[15] = mk(4'h1, 4'h0, 0, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[16] = mk(4'h0, 4'h0, 0, 1, ex(4'h0, 0, 4'h0, 0, 0, 0, 0, 0));
        vecs[17] = mk(4'h1, 4'h0, 0, 1, ex(4'h0, 0, 4'h0, 0, 0, 0, 0, 0));
        vecs[18] = mk(4'h1, 4'h0, 0, 0, ex(4'h1, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[19] = mk(4'h0, 4'h0, 0, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[20] = mk(4'h0, 4'h3, 0, 0, ex(4'h0, 1, 4'h1, 1, 0, 1, 0, 1));
        vecs[21] = mk(4'h0, 4'h0, 1, 0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1));
        vecs[22] = mk(4'h0, 4'h0, 0, 1, ex(4'h0, 0, 4'h0, 0, 0, 0, 0, 0));

        #1;
        check("reset_a", {16'h0, out_a}, 32'h0);
        check("reset_b", {16'h0, out_b}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            dl_a = vecs[i].dl; tok_a = vecs[i].tok; rdy_a = vecs[i].rdy; clr_a = vecs[i].clr;
            @(negedge clk);
            check($sformatf("vec%0d", i), {16'h0, out_a}, {16'h0, vecs[i].exp});
        end
        dl_a = '0; tok_a = '0; rdy_a = 1'b0; clr_a = 1'b0;

        // Reset in the middle of a walk with three processes logged.
        dl_a = 4'h1; @(negedge clk);
        dl_a = 4'h0; @(negedge clk);
        tok_a = 4'h2; @(negedge clk);
        tok_a = 4'h4; @(negedge clk);
        tok_a = 4'h0;
        check("walk_before_reset", {16'h0, out_a}, {16'h0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1)});
        rst = 1'b1;
        #1;
        check("reset_mid_walk", {16'h0, out_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {16'h0, out_a}, 32'h0);

        // Two-deep chain overflows on the second distinct non-origin token.
        dl_b = 4'h1; @(negedge clk);
        check("b_origin", {16'h0, out_b}, {16'h0, ex(4'h1, 1, 4'h0, 0, 0, 0, 0, 1)});
        dl_b = 4'h0; @(negedge clk);
        check("b_walk", {16'h0, out_b}, {16'h0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1)});
        tok_b = 4'h2; @(negedge clk);
        check("b_append", {16'h0, out_b}, {16'h0, ex(4'h0, 1, 4'h0, 0, 0, 0, 0, 1)});
        tok_b = 4'h4; @(negedge clk);
        check("b_overflow", {16'h0, out_b}, {16'h0, ex(4'h0, 1, 4'h0, 1, 0, 0, 1, 1)});
        tok_b = 4'h0; rdy_b = 1'b1; @(negedge clk);
        check("b_beat1", {16'h0, out_b}, {16'h0, ex(4'h0, 1, 4'h0, 1, 1, 1, 1, 1)});
        @(negedge clk);
        check("b_halt", {16'h0, out_b}, {16'h0, ex(4'h0, 1, 4'h0, 0, 0, 0, 1, 1)});
        rdy_b = 1'b0; clr_b = 1'b1; @(negedge clk);
        check("b_clear", {16'h0, out_b}, 32'h0);
        clr_b = 1'b0;

`ifdef DEADLOCK_REPORT_TIMEOUT_EN
        begin
            int seen;
            seen = -1;
            dl_a = 4'h8; @(negedge clk);
            check("to_origin", {16'h0, out_a}, {16'h0, ex(4'h8, 1, 4'h0, 0, 0, 0, 0, 1)});
            dl_a = 4'h0; @(negedge clk);
            for (int k = 1; k <= 30 && seen < 0; k++) begin
                @(negedge clk);
                if (tclr_a != 4'h0) seen = k;
            end
            check("to_cycles", seen, 10);
            check("to_report", {16'h0, out_a}, {16'h0, ex(4'h0, 1, 4'h8, 1, 3, 1, 2, 1)});
            rdy_a = 1'b1; @(negedge clk);
            check("to_halt", {16'h0, out_a}, {16'h0, ex(4'h0, 1, 4'h0, 0, 0, 0, 2, 1)});
            rdy_a = 1'b0; clr_a = 1'b1; @(negedge clk);
            check("to_clear", {16'h0, out_a}, 32'h0);
            clr_a = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/photon_hls_deadlock_report_unit.md
Name: photon_hls_deadlock_report_unit

Overview:
- Central controller at the other end of the per-process deadlock detect units in an HLS dataflow region.
- Watches every unit's deadlock flag and picks one origin process. Pulses that unit's origin input and broadcasts dl_detect_in.
- Logs the token walk around the dependency cycle, closes the walk with token_clear, then streams the recorded process chain out over a valid/ready report port.

Parameters:
- PROC_NUM, 4, number of dataflow processes / detect units
- CHAIN_DEPTH, 4, entries in chain log (origin included); must be >= 2
- IDX_W, 2, width of a process index; must be >= clog2(PROC_NUM), min 1
- WALK_TIMEOUT, 255, WALK cycles without a new logged process before abort (only with optional feature)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- dl_in_vec  in  PROC_NUM  dl_detect_out of each unit, bit i = process i
- token_seen_vec  in  PROC_NUM  bit i = OR of process i's token_in_vec
- origin_vec  out  PROC_NUM  one-hot origin pulse to units
- dl_detect_bcast  out  1  dl_detect_in to all units
- token_clear_vec  out  PROC_NUM  one-hot token_clear to units
- report_valid  out  1  chain entry valid
- report_idx  out  IDX_W  process index of current entry
- report_last  out  1  final chain entry
- report_status  out  2  00 closed, 01 overflow, 10 timeout
- report_ready  in  1  consumer accepts entry
- deadlock_flag  out  1  sticky: deadlock seen since last clear
- clear  in  1  synchronous return to IDLE, clears flag and log

Behaviour:
- Reset (async, high): state IDLE; all outputs 0; log count, rd_ptr and watchdog cleared. Reset mid-walk or mid-report abandons everything.
- All outputs registered.
- IDLE:
  - If any dl_in_vec bit is set, latch the lowest set index as org.
  - Write log[0]=org, count=1, go ORIGIN.
  - Latency: dl_in seen at edge N, origin pulse visible in cycle after edge N.
- ORIGIN (1 cycle):
  - origin_vec=1<<org.
  - dl_detect_bcast=1; stays 1 until state returns to IDLE.
  - deadlock_flag=1. Go WALK.
- WALK, each cycle:
  - If token_seen_vec[org]=1: cycle closed; token_clear_vec=1<<org for exactly one cycle; status=00; go REPORT. Origin close has priority over appends in the same cycle.
  - Else take the lowest set bit of token_seen_vec that is not already in log[0..count-1]:
    - count<CHAIN_DEPTH: append it and count++.
    - count==CHAIN_DEPTH: status=01, go REPORT.
  - Indices already in the log are ignored (no append, no status change).
- REPORT:
  - report_valid=1, report_idx=log[rd_ptr], report_last=(rd_ptr==count-1).
  - report_status stays stable throughout REPORT.
  - On valid&ready, rd_ptr++. If the beat was last, go HALT and drop valid next cycle.
  - Outputs hold while ready=0.
- HALT:
  - dl_detect_bcast stays 1 so units stay frozen. deadlock_flag stays 1.
  - New dl_in_vec activity is ignored until clear.
- clear=1 in any state: next state IDLE, flag/count/rd_ptr/status cleared, all pulses 0.
  - clear and reset: reset wins.
  - clear and a dl_in rising in the same IDLE cycle: clear wins, detection starts next cycle.
- Widths: count and rd_ptr are clog2(CHAIN_DEPTH)+1 bits. No wrap; overflow handled as above.

Optional Feature:
- Macro: DEADLOCK_REPORT_TIMEOUT_EN.
- With it defined:
  - An 8-bit (or wider to fit WALK_TIMEOUT) watchdog runs in WALK.
  - It resets on every append and on WALK entry.
  - When it reaches WALK_TIMEOUT with no close or append: status=10, token_clear_vec=1<<org for one cycle, go REPORT.
- Without it: no watchdog logic; WALK waits indefinitely for close or overflow.

Test Plan:
- Reset asserted mid-WALK with count=3 -> same cycle all outputs 0; after release, dl_in_vec=0 keeps IDLE with bcast=0.
- dl_in_vec=4'b0110 -> org=1; origin_vec=4'b0010 for 1 cycle; then token_seen 4'b0100, 4'b1000, 4'b0010 on successive cycles -> token_clear_vec=4'b0010 once. Report beats 1,2,3 with last on 3, status 00, flag=1.
- CHAIN_DEPTH=2, org=0, token_seen 4'b0010 then 4'b0100 -> status 01; report beats 0,1, last on 1.
- Report with report_ready held 0 for 5 cycles -> valid/idx/last stable; then ready=1 -> one beat per cycle.
- Token_seen repeats an already-logged index 2 (4'b0100 twice) -> logged once; count unchanged by the repeat.
- DEADLOCK_REPORT_TIMEOUT_EN, WALK_TIMEOUT=10, no token_seen after origin -> at cycle 10 of WALK token_clear pulses, status 10, single report beat idx=org with last=1. Then clear=1 -> IDLE, flag=0, bcast=0.
